// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline encodings for the memory/write-back boundary.
// Latency: none (constants only).
// Backpressure: not applicable.
package mem_wb_stage_pkg;

  // Write-back source select
  localparam logic [1:0] WB_SEL_ALU     = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD    = 2'b01;
  localparam logic [1:0] WB_SEL_PC      = 2'b10;
  localparam logic [1:0] WB_SEL_ALU_ALT = 2'b11;

  // Load access size
  localparam logic [1:0] LS_BYTE  = 2'b00;
  localparam logic [1:0] LS_HALF  = 2'b01;
  localparam logic [1:0] LS_WORD  = 2'b10;
  localparam logic [1:0] LS_DWORD = 2'b11;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Extracts the addressed lane from a load word and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result.
module load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANE_W = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [LANE_W-1:0] addr_lo,
  input  logic [1:0]        load_size,
  input  logic              load_unsigned,
  output logic [DATA_W-1:0] data
);

  logic [1:0]        size_eff;
  logic [LANE_W-1:0] off;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic              sign;

  // Align the lane to bit 0, then mask to the access size and extend
  always_comb begin
    size_eff = load_size;
    // A 32-bit datapath has no dword; treat it as a full word
    if (DATA_W == 32 && load_size == LS_DWORD) size_eff = LS_WORD;

    // Offset bits below the access size are ignored (naturally aligned lane)
    off = addr_lo;
    case (size_eff)
      LS_HALF:  off[0]   = 1'b0;
      LS_WORD:  off[1:0] = 2'b00;
      LS_DWORD: off      = '0;
      default:  ;
    endcase

    shifted = rdata >> {off, 3'b000};

    case (size_eff)
      LS_BYTE: begin mask = DATA_W'(8'hFF);         sign = shifted[7];        end
      LS_HALF: begin mask = DATA_W'(16'hFFFF);      sign = shifted[15];       end
      LS_WORD: begin mask = DATA_W'(32'hFFFF_FFFF); sign = shifted[31];       end
      default: begin mask = '1;                     sign = shifted[DATA_W-1]; end
    endcase

    data = shifted & mask;
    if (!load_unsigned && sign) data = data | ~mask;
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: selects and extends write-back data into a 2-entry skid buffer.
// Latency: 1 cycle from input fire to out_valid when out_ready is high.
// Backpressure: in_ready is registered and high iff the skid entry is empty.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int LANE_W  = $clog2(DATA_W/8)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         wb_sel,
  input  logic [1:0]         load_size,
  input  logic               load_unsigned,
  input  logic [LANE_W-1:0]  addr_lo,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [DATA_W-1:0]  pc_plus4,
  input  logic [RADDR_W-1:0] rd,
  input  logic               reg_write,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RADDR_W-1:0] wb_rd,
  output logic               wb_we,
  output logic [DATA_W-1:0]  wb_data,
  output logic [31:0]        retired
);

  logic [DATA_W-1:0]  load_data;
  logic [DATA_W-1:0]  new_data;
  logic               new_we;
  logic               in_fire;
  logic               out_fire;

  logic               main_vld_q, main_vld_d;
  logic [RADDR_W-1:0] main_rd_q,  main_rd_d;
  logic               main_we_q,  main_we_d;
  logic [DATA_W-1:0]  main_dat_q, main_dat_d;
  logic               skid_vld_q, skid_vld_d;
  logic [RADDR_W-1:0] skid_rd_q,  skid_rd_d;
  logic               skid_we_q,  skid_we_d;
  logic [DATA_W-1:0]  skid_dat_q, skid_dat_d;
  logic               in_ready_q, in_ready_d;
  logic [31:0]        retired_q,  retired_d;

  load_align #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_load_align (
    .rdata         (mem_rdata),
    .addr_lo       (addr_lo),
    .load_size     (load_size),
    .load_unsigned (load_unsigned),
    .data          (load_data)
  );

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = main_vld_q && out_ready;

  // Form the write-back value and enable from the incoming entry
  always_comb begin
    case (wb_sel)
      WB_SEL_LOAD: new_data = load_data;
      WB_SEL_PC:   new_data = pc_plus4;
      default:     new_data = alu_result;
    endcase
    new_we = reg_write && (rd != '0);
  end

  // Skid-buffer next state: flush first, then drain, then fill
  always_comb begin
    main_vld_d = main_vld_q;
    main_rd_d  = main_rd_q;
    main_we_d  = main_we_q;
    main_dat_d = main_dat_q;
    skid_vld_d = skid_vld_q;
    skid_rd_d  = skid_rd_q;
    skid_we_d  = skid_we_q;
    skid_dat_d = skid_dat_q;
    retired_d  = retired_q;

    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else begin
      if (out_fire) begin
        retired_d = retired_q + 32'd1;
        if (skid_vld_q) begin
          main_rd_d  = skid_rd_q;
          main_we_d  = skid_we_q;
          main_dat_d = skid_dat_q;
          skid_vld_d = 1'b0;
        end else begin
          main_vld_d = 1'b0;
        end
      end
      // in_fire implies skid is empty, so it never collides with the move above
      if (in_fire) begin
        if (!main_vld_q || out_fire) begin
          main_vld_d = 1'b1;
          main_rd_d  = rd;
          main_we_d  = new_we;
          main_dat_d = new_data;
        end else begin
          skid_vld_d = 1'b1;
          skid_rd_d  = rd;
          skid_we_d  = new_we;
          skid_dat_d = new_data;
        end
      end
    end
    // Registered ready: reflects skid occupancy after this edge
    in_ready_d = !skid_vld_d;
  end

  // State registers; async reset drops both entries and zeroes the outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld_q <= 1'b0;
      main_rd_q  <= '0;
      main_we_q  <= 1'b0;
      main_dat_q <= '0;
      skid_vld_q <= 1'b0;
      skid_rd_q  <= '0;
      skid_we_q  <= 1'b0;
      skid_dat_q <= '0;
      in_ready_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      main_rd_q  <= main_rd_d;
      main_we_q  <= main_we_d;
      main_dat_q <= main_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_rd_q  <= skid_rd_d;
      skid_we_q  <= skid_we_d;
      skid_dat_q <= skid_dat_d;
      in_ready_q <= in_ready_d;
      retired_q  <= retired_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_vld_q;
  assign wb_rd     = main_rd_q;
  assign wb_we     = main_we_q;
  assign wb_data   = main_dat_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table, corner sequences, random stream.
// Latency: checks outputs one cycle after input fire.
// Backpressure: model is an ordered queue of at most two held entries.
module tb_mem_wb_stage;

  typedef struct packed {
    logic [1:0]  sel;
    logic [1:0]  lsz;
    logic        uns;
    logic [1:0]  alo;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rw;
  } stim_t;

  typedef struct packed {
    logic [31:0] data;
    logic        we;
    logic [4:0]  rd;
  } exp_t;

  typedef struct packed {
    stim_t       s;
    logic [31:0] exp_data;
    logic        exp_we;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  wb_sel = '0;
  logic [1:0]  load_size = '0;
  logic        load_unsigned = 1'b0;
  logic [1:0]  addr_lo = '0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] alu_result = '0;
  logic [31:0] pc_plus4 = '0;
  logic [4:0]  rd = '0;
  logic        reg_write = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [31:0] wb_data;
  logic [31:0] retired;

  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        q[$];
  logic [31:0] got[$];
  logic [31:0] model_ret = '0;

  mem_wb_stage dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .wb_sel        (wb_sel),
    .load_size     (load_size),
    .load_unsigned (load_unsigned),
    .addr_lo       (addr_lo),
    .mem_rdata     (mem_rdata),
    .alu_result    (alu_result),
    .pc_plus4      (pc_plus4),
    .rd            (rd),
    .reg_write     (reg_write),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .wb_rd         (wb_rd),
    .wb_we         (wb_we),
    .wb_data       (wb_data),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: byte-count arithmetic on the load word, no lane muxing
  function automatic exp_t ref_wb(input stim_t s);
    exp_t e;
    longint unsigned nb, off, v;
    case (s.sel)
      2'd1: begin
        nb  = (s.lsz == 2'd3) ? 4 : (64'd1 << s.lsz);
        off = (64'(s.alo) / nb) * nb;
        v   = (64'(s.rdata) >> (8 * off)) % (64'd1 << (8 * nb));
        if (!s.uns && v >= (64'd1 << (8 * nb - 1)))
          v = v + (64'd1 << 32) - (64'd1 << (8 * nb));
        e.data = v[31:0];
      end
      2'd2:    e.data = s.pc;
      default: e.data = s.alu;
    endcase
    e.rd = s.rd;
    e.we = s.rw && (s.rd != 0);
    return e;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.sel   = 2'($urandom_range(0, 3));
    s.lsz   = 2'($urandom_range(0, 3));
    s.uns   = 1'($urandom_range(0, 1));
    s.alo   = 2'($urandom_range(0, 3));
    s.rdata = $urandom;
    s.alu   = $urandom;
    s.pc    = $urandom;
    s.rd    = 5'($urandom_range(0, 31));
    s.rw    = 1'($urandom_range(0, 1));
    return s;
  endfunction

  function automatic stim_t alu_stim(input logic [31:0] v, input logic [4:0] r);
    stim_t s;
    s = '0;
    s.sel = 2'd0;
    s.alu = v;
    s.rd  = r;
    s.rw  = 1'b1;
    return s;
  endfunction

  // One cycle: check DUT against the model at negedge, drive inputs, advance the model
  task automatic step(input bit iv, input bit ordy, input bit fl, input stim_t s);
    bit rdy_m;
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("retired", 64'(retired), 64'(model_ret));
    if (q.size() > 0) begin
      chk("wb_data", 64'(wb_data), 64'(q[0].data));
      chk("wb_we", 64'(wb_we), 64'(q[0].we));
      chk("wb_rd", 64'(wb_rd), 64'(q[0].rd));
    end
    in_valid      = iv;
    out_ready     = ordy;
    flush         = fl;
    wb_sel        = s.sel;
    load_size     = s.lsz;
    load_unsigned = s.uns;
    addr_lo       = s.alo;
    mem_rdata     = s.rdata;
    alu_result    = s.alu;
    pc_plus4      = s.pc;
    rd            = s.rd;
    reg_write     = s.rw;
    rdy_m = (q.size() < 2);
    if (fl) begin
      q.delete();
    end else begin
      if (ordy && q.size() > 0) begin
        got.push_back(q[0].data);
        void'(q.pop_front());
        model_ret = model_ret + 32'd1;
      end
      if (iv && rdy_m) q.push_back(ref_wb(s));
    end
  endtask

  vec_t        vecs[12];
  logic [31:0] ret_snap;

  initial begin
    vecs[0]  = '{s: '{2'd1, 2'd0, 1'b0, 2'd2, 32'h12A45678, 32'h0, 32'h0, 5'd5, 1'b1},        exp_data: 32'hFFFFFFA4, exp_we: 1'b1};
    vecs[1]  = '{s: '{2'd1, 2'd0, 1'b1, 2'd2, 32'h12A45678, 32'h0, 32'h0, 5'd5, 1'b1},        exp_data: 32'h000000A4, exp_we: 1'b1};
    vecs[2]  = '{s: '{2'd2, 2'd0, 1'b0, 2'd0, 32'h0, 32'h1111, 32'h00400010, 5'd31, 1'b1},    exp_data: 32'h00400010, exp_we: 1'b1};
    vecs[3]  = '{s: '{2'd0, 2'd0, 1'b0, 2'd0, 32'h0, 32'hDEADBEEF, 32'h0, 5'd0, 1'b1},        exp_data: 32'hDEADBEEF, exp_we: 1'b0};
    vecs[4]  = '{s: '{2'd3, 2'd0, 1'b0, 2'd0, 32'h0, 32'h13579BDF, 32'h0, 5'd9, 1'b1},        exp_data: 32'h13579BDF, exp_we: 1'b1};
    vecs[5]  = '{s: '{2'd1, 2'd1, 1'b0, 2'd3, 32'h80017FFF, 32'h0, 32'h0, 5'd3, 1'b1},        exp_data: 32'hFFFF8001, exp_we: 1'b1};
    vecs[6]  = '{s: '{2'd1, 2'd1, 1'b1, 2'd1, 32'h80017FFF, 32'h0, 32'h0, 5'd3, 1'b1},        exp_data: 32'h00007FFF, exp_we: 1'b1};
    vecs[7]  = '{s: '{2'd1, 2'd2, 1'b0, 2'd3, 32'h89ABCDEF, 32'h0, 32'h0, 5'd4, 1'b1},        exp_data: 32'h89ABCDEF, exp_we: 1'b1};
    vecs[8]  = '{s: '{2'd1, 2'd3, 1'b0, 2'd1, 32'h89ABCDEF, 32'h0, 32'h0, 5'd4, 1'b1},        exp_data: 32'h89ABCDEF, exp_we: 1'b1};
    vecs[9]  = '{s: '{2'd1, 2'd0, 1'b0, 2'd0, 32'h0000007F, 32'h0, 32'h0, 5'd6, 1'b1},        exp_data: 32'h0000007F, exp_we: 1'b1};
    vecs[10] = '{s: '{2'd1, 2'd0, 1'b0, 2'd3, 32'h80000000, 32'h0, 32'h0, 5'd6, 1'b1},        exp_data: 32'hFFFFFF80, exp_we: 1'b1};
    vecs[11] = '{s: '{2'd0, 2'd0, 1'b0, 2'd0, 32'h0, 32'h0BADF00D, 32'h0, 5'd7, 1'b0},        exp_data: 32'h0BADF00D, exp_we: 1'b0};

    // Reset: asynchronous clear, in_ready low while held
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    @(posedge clk); #1;
    chk("rst_in_ready_held", 64'(in_ready), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Single-entry vectors with the consumer always ready
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b0, vecs[i].s);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_data", i), 64'(wb_data), 64'(vecs[i].exp_data));
      chk($sformatf("vec%0d_we", i), 64'(wb_we), 64'(vecs[i].exp_we));
      chk($sformatf("vec%0d_rd", i), 64'(wb_rd), 64'(vecs[i].s.rd));
      step(1'b0, 1'b1, 1'b0, rand_stim());
    end
    step(1'b0, 1'b1, 1'b0, rand_stim());
    chk("vec_retired", 64'(retired), 64'd12);

    // Stall: A held, B in skid, C refused, then ordered release
    got.delete();
    step(1'b1, 1'b0, 1'b0, alu_stim(32'hA, 5'd1));
    step(1'b1, 1'b0, 1'b0, alu_stim(32'hB, 5'd2));
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, alu_stim(32'hC, 5'd3));
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_held_A", 64'(wb_data), 64'hA);
    end
    step(1'b1, 1'b1, 1'b0, alu_stim(32'hC, 5'd3));
    step(1'b1, 1'b1, 1'b0, alu_stim(32'hC, 5'd3));
    step(1'b0, 1'b1, 1'b0, alu_stim(32'h0, 5'd0));
    step(1'b0, 1'b1, 1'b0, alu_stim(32'h0, 5'd0));
    chk("order_count", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      chk("order_0", 64'(got[0]), 64'hA);
      chk("order_1", 64'(got[1]), 64'hB);
      chk("order_2", 64'(got[2]), 64'hC);
    end

    // Flush with both entries full and a new entry offered
    step(1'b1, 1'b0, 1'b0, alu_stim(32'h21, 5'd4));
    step(1'b1, 1'b0, 1'b0, alu_stim(32'h22, 5'd4));
    ret_snap = model_ret;
    step(1'b1, 1'b1, 1'b1, alu_stim(32'h23, 5'd4));
    @(posedge clk); #1;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_retired", 64'(retired), 64'(ret_snap));
    step(1'b0, 1'b0, 1'b0, alu_stim(32'h0, 5'd0));

    // Counter wrap from all-ones
    step(1'b1, 1'b0, 1'b0, alu_stim(32'h31, 5'd5));
    force dut.retired_q = 32'hFFFFFFFF;
    #1 release dut.retired_q;
    model_ret = 32'hFFFFFFFF;
    step(1'b0, 1'b1, 1'b0, alu_stim(32'h0, 5'd0));
    step(1'b0, 1'b0, 1'b0, alu_stim(32'h0, 5'd0));
    chk("wrap_retired", 64'(retired), 64'd0);

    // Reset mid-stall drops both entries asynchronously
    step(1'b1, 1'b0, 1'b0, alu_stim(32'h41, 5'd6));
    step(1'b1, 1'b0, 1'b0, alu_stim(32'h42, 5'd7));
    step(1'b0, 1'b0, 1'b0, alu_stim(32'h0, 5'd0));
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_wb_data", 64'(wb_data), 64'd0);
    chk("arst_wb_we", 64'(wb_we), 64'd0);
    chk("arst_wb_rd", 64'(wb_rd), 64'd0);
    chk("arst_retired", 64'(retired), 64'd0);
    q.delete();
    model_ret = '0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);

    // Random stream against the queue model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) < 3),
           ($urandom_range(0, 29) == 0), rand_stim());
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, rand_stim());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter RADDR_W, default 5, register-index width.
REQ-003 SHALL have parameter LANE_W, default $clog2(DATA_W/8), byte-offset width.
REQ-004 SHALL have port clk  input  1  clock; all state on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port flush  input  1  drop all held and incoming entries.
REQ-007 SHALL have port in_valid  input  1  upstream entry present.
REQ-008 SHALL have port in_ready  output  1  stage can accept; registered (skid-buffer output).
REQ-009 SHALL have port wb_sel  input  2  source select: 00 alu_result, 01 load data, 10 pc_plus4, 11 alu_result.
REQ-010 SHALL have port load_size  input  2  00 byte, 01 half, 10 word, 11 dword (word if DATA_W=32).
REQ-011 SHALL have port load_unsigned  input  1  1 zero-extend, 0 sign-extend.
REQ-012 SHALL have port addr_lo  input  LANE_W  byte offset of the load address.
REQ-013 SHALL have ports mem_rdata, alu_result, pc_plus4  input  DATA_W each  candidate write-back values.
REQ-014 SHALL have ports rd  input  RADDR_W and reg_write  input  1  destination and write enable.
REQ-015 SHALL have port out_valid  output  1  held entry presented to the register file.
REQ-016 SHALL have port out_ready  input  1  register-file write port accepts this cycle.
REQ-017 SHALL have ports wb_rd  output  RADDR_W, wb_we  output  1, wb_data  output  DATA_W  write-back triple.
REQ-018 SHALL have port retired  output  32  count of entries consumed by the output handshake.

Function
REQ-019 Input fire SHALL be in_valid&&in_ready; output fire SHALL be out_valid&&out_ready.
REQ-020 Write-back data SHALL be selected and load-extended at input fire and stored; outputs SHALL come only from registers (latency 1 cycle when out_ready=1).
REQ-021 Load extraction SHALL take the lane mem_rdata[8*addr_lo +: size], ignoring addr_lo bits below the access size, then extend it to DATA_W per load_unsigned.
REQ-022 wb_we SHALL be stored as reg_write && (rd != 0); an entry with wb_we=0 SHALL still flow and retire.
REQ-023 Storage SHALL be a 2-entry skid buffer (main, skid); in_ready SHALL be 1 iff the skid entry is empty.
REQ-024 When main is empty or firing, an input fire SHALL load main; when main is stalled, an input fire SHALL load skid.
REQ-025 On output fire with skid full, skid SHALL move to main, and in_ready SHALL rise on the next cycle.
REQ-026 Order SHALL be preserved; no entry SHALL be duplicated or lost without flush.
REQ-027 flush SHALL empty both entries at the next edge; an input fire in the same cycle SHALL be discarded; flush SHALL take priority over all other events.
REQ-028 retired SHALL increment by 1 per output fire, wrap from 0xFFFFFFFF to 0, and SHALL NOT count flushed entries.
REQ-029 out_valid=0 SHALL leave wb_we, wb_rd and wb_data don't-care to consumers; implementation SHALL hold the last values.

Reset
REQ-030 rst SHALL asynchronously clear main and skid valid bits, wb_rd, wb_we, wb_data and retired to 0.
REQ-031 During reset in_ready SHALL be 0; it SHALL be 1 from the first edge after rst deasserts.
REQ-032 rst mid-stall SHALL discard both held entries without retiring them.

Structure
REQ-033 The wb_sel and load_size encodings SHALL be named constants in the shared pipeline package.
REQ-034 Load extraction SHALL be one combinational sub-module, load_align, parameterised by DATA_W.
REQ-035 The skid buffer and counter SHALL live in mem_wb_stage.

Verification
REQ-036 wb_sel=01, load_size=00, signed, addr_lo=2, mem_rdata=0x12A45678 -> wb_data=0xFFFFFFA4; same stimulus unsigned -> 0x000000A4.
REQ-037 wb_sel=10, pc_plus4=0x00400010, rd=31, reg_write=1 -> wb_rd=31, wb_we=1, wb_data=0x00400010 one cycle later.
REQ-038 rd=0, reg_write=1 -> wb_we=0, out_valid=1, retired increments.
REQ-039 Stream A,B,C with out_ready=0 for 3 cycles -> A held, B in skid, in_ready=0, C stalled; on release the order is A,B,C with no loss.
REQ-040 flush with main+skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1, retired unchanged.
REQ-041 Preload retired=0xFFFFFFFF (force) + one output fire -> retired=0; assert rst mid-stream -> all outputs 0 asynchronously.
